// File: rtl/usbsd_rack_in.sv
`default_nettype none
// ============================================================================
//  Module      : usbsd_rack_in
//  Description : Avalon-MM slave input PIO. Synchronises asynchronous status
//                lines from the USB/SD controller, latches selected edges into
//                a sticky write-1-to-clear capture register, and raises a
//                maskable level interrupt for the CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module usbsd_rack_in #(
  parameter int WIDTH       = 1,  // number of input lines (1..32)
  parameter int SYNC_STAGES = 2,  // synchroniser depth (2..4)
  parameter int EDGE_TYPE   = 0   // 0 rising, 1 falling, 2 any edge
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Arm counter saturates at SYNC_STAGES+1 (max 5), so 3 bits is enough.
  localparam int              C_CNT_W   = 3;
  localparam logic [C_CNT_W-1:0] C_ARM_MAX = C_CNT_W'(SYNC_STAGES + 1);

  localparam logic [1:0] C_ADDR_DATA = 2'd0;
  localparam logic [1:0] C_ADDR_RSVD = 2'd1;
  localparam logic [1:0] C_ADDR_MASK = 2'd2;
  localparam logic [1:0] C_ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_edgecap;
  logic [WIDTH-1:0]   r_irqmask;
  logic               r_irq;
  logic [C_CNT_W-1:0] r_arm_cnt;

  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   w_edge_raw;
  logic [WIDTH-1:0]   w_edge;
  logic [WIDTH-1:0]   w_clr;
  logic [WIDTH-1:0]   w_rd_field;
  logic               w_armed;
  logic               w_wr;
  logic               w_wr_mask;
  logic               w_wr_clr;
  logic               w_unused_wdata;

  // Bits of writedata above WIDTH carry no meaning for this block.
  assign w_unused_wdata = ^writedata;

  // --------------------------------------------------------------------------
  // Synchroniser chain: stage 0 takes the raw pin, the last stage is "s".
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      // First flop samples the asynchronous pin.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync[gi] <= '0;
        else       r_sync[gi] <= in_port;
      end
    end else begin : g_rest
      // Subsequent flops shift the sampled value along the chain.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync[gi] <= '0;
        else       r_sync[gi] <= r_sync[gi-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Previous synchronised value for edge comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= w_s;
  end

  // --------------------------------------------------------------------------
  // Edge detection, selected at elaboration time.
  // --------------------------------------------------------------------------
  if (EDGE_TYPE == 0) begin : g_rise
    assign w_edge_raw = w_s & ~r_prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign w_edge_raw = ~w_s & r_prev;
  end else begin : g_any
    assign w_edge_raw = w_s ^ r_prev;
  end

  // Arm counter: holds off edge detection until the chain and prev have
  // been refilled with real pin data, so a line already high at reset
  // release does not look like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_arm_cnt <= '0;
    else if (r_arm_cnt != C_ARM_MAX) r_arm_cnt <= r_arm_cnt + 1'b1;
  end

  assign w_armed = (r_arm_cnt == C_ARM_MAX);
  assign w_edge  = w_armed ? w_edge_raw : '0;

  // --------------------------------------------------------------------------
  // Avalon write decode.
  // --------------------------------------------------------------------------
  assign w_wr      = chipselect & ~write_n;
  assign w_wr_mask = w_wr & (address == C_ADDR_MASK);
  assign w_wr_clr  = w_wr & (address == C_ADDR_CAP);
  assign w_clr     = w_wr_clr ? writedata[WIDTH-1:0] : '0;

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_irqmask <= '0;
    else if (w_wr_mask) r_irqmask <= writedata[WIDTH-1:0];
  end

  // Sticky capture, write-1-to-clear. Set is applied after clear so a new
  // edge in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_edgecap <= '0;
    else       r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
  end

  // Registered level interrupt from masked captures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= |(r_edgecap & r_irqmask);
  end

  assign irq = r_irq;

  // Zero-wait-state read mux; reads have no side effects.
  always_comb begin
    w_rd_field = '0;
    case (address)
      C_ADDR_DATA: w_rd_field = w_s;
      C_ADDR_RSVD: w_rd_field = '0;
      C_ADDR_MASK: w_rd_field = r_irqmask;
      C_ADDR_CAP:  w_rd_field = r_edgecap;
      default:     w_rd_field = '0;
    endcase
  end

  assign readdata = 32'(w_rd_field);

endmodule
`default_nettype wire

// File: tb/tb_usbsd_rack_in.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_usbsd_rack_in
//  Description : Scoreboard bench for usbsd_rack_in; three configurations
//                share one bus and are compared against a history-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usbsd_rack_in;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  pin;
  logic [31:0] rdv  [ND];
  logic        irqv [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usbsd_rack_in #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pin[0:0]),
    .readdata(rdv[0]), .irq(irqv[0]));

  usbsd_rack_in #(.WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(2)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pin),
    .readdata(rdv[1]), .irq(irqv[1]));

  usbsd_rack_in #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(pin),
    .readdata(rdv[2]), .irq(irqv[2]));

  function automatic int cfg_w(int d);  return (d == 0) ? 1 : 4; endfunction
  function automatic int cfg_n(int d);  return (d == 1) ? 3 : 2; endfunction
  function automatic int cfg_e(int d);  return (d == 0) ? 0 : ((d == 1) ? 2 : 1); endfunction
  function automatic logic [31:0] wmask(int d); return (32'd1 << cfg_w(d)) - 32'd1; endfunction

  // Reference model: every pin sample since reset release is kept; the
  // synchronised value after t clocks is simply the sample from N clocks ago.
  int          cyc   [ND] = '{0, 0, 0};
  logic [31:0] hist  [ND][$];
  logic [31:0] cap   [ND] = '{0, 0, 0};
  logic [31:0] msk   [ND] = '{0, 0, 0};
  logic        m_irq [ND] = '{0, 0, 0};

  function automatic logic [31:0] sval(int d, int t);
    if (t < cfg_n(d)) return 32'd0;
    return hist[d][t - cfg_n(d)];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        cyc[d] = 0; hist[d].delete(); cap[d] = 0; msk[d] = 0; m_irq[d] = 0;
      end else begin
        logic [31:0] s, p, e;
        s = sval(d, cyc[d]);
        p = sval(d, cyc[d] - 1);
        case (cfg_e(d))
          0:       e = s & ~p;
          1:       e = ~s & p;
          default: e = s ^ p;
        endcase
        e = e & wmask(d);
        if (cyc[d] < cfg_n(d) + 1) e = 0;
        m_irq[d] = |(cap[d] & msk[d]);
        if (chipselect && !write_n && address == 2'd3) cap[d] = cap[d] & ~writedata;
        cap[d] = cap[d] | e;
        if (chipselect && !write_n && address == 2'd2) msk[d] = writedata & wmask(d);
        hist[d].push_back({28'd0, pin} & wmask(d));
        cyc[d] = cyc[d] + 1;
      end
    end
  end

  function automatic logic [31:0] exp_rd(int d, logic [1:0] a);
    if (reset) return 32'd0;
    case (a)
      2'd0:    return sval(d, cyc[d]);
      2'd2:    return msk[d];
      2'd3:    return cap[d];
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    int          d;
    logic [1:0]  a;
    logic [31:0] e;
  } rd_t;
  rd_t q[$];

  // Monitor: irq every cycle, pending read expectations on each negedge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      logic ei;
      ei = reset ? 1'b0 : m_irq[d];
      checks++;
      if (irqv[d] !== ei) begin
        errors++;
        $display("FAIL irq dut%0d t=%0t got %b exp %b", d, $time, irqv[d], ei);
      end
    end
    while (q.size() > 0) begin
      rd_t r;
      r = q.pop_front();
      checks++;
      if (rdv[r.d] !== r.e) begin
        errors++;
        $display("FAIL rd dut%0d addr%0d t=%0t got %h exp %h", r.d, r.a, $time, rdv[r.d], r.e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus cycle, queue the expected readdata for every instance.
  task automatic cyc_op(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs; write_n = wn; address = a; writedata = d;
    for (int k = 0; k < ND; k++) q.push_back('{k, a, exp_rd(k, a)});
    tick();
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) cyc_op(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic peek(input logic [1:0] a);
    chipselect = 1'b0; write_n = 1'b1; address = a;
    #1;
  endtask

  initial begin
    reset = 1'b1; pin = 4'h0; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq0", {31'd0, irqv[0]}, 32'd0);
    chk("rst_rd0",  rdv[0], 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) cyc_op(1'b0, 1'b1, 2'(a), 32'd0);
    idle(4, 2'd3);

    // Rising edge on line 0, capture after three clocks.
    pin = 4'h1;
    idle(3, 2'd3);
    peek(2'd3);
    chk("t1_cap", rdv[0], 32'd1);
    idle(2, 2'd3);
    chk("t1_irq_masked", {31'd0, irqv[0]}, 32'd0);
    cyc_op(1'b1, 1'b0, 2'd2, 32'h1);
    tick();
    chk("t1_irq_on", {31'd0, irqv[0]}, 32'd1);

    // Clear, then clear coincident with a new rising edge.
    cyc_op(1'b1, 1'b0, 2'd3, 32'hF);
    idle(1, 2'd3);
    chk("t2_irq_off", {31'd0, irqv[0]}, 32'd0);
    pin = 4'h0;
    idle(5, 2'd3);
    cyc_op(1'b1, 1'b0, 2'd3, 32'hF);
    pin = 4'h1;
    idle(2, 2'd3);
    cyc_op(1'b1, 1'b0, 2'd3, 32'h1);
    peek(2'd3);
    chk("t2_edge_wins", rdv[0], 32'd1);

    // Line held high through reset release must not capture.
    pin = 4'hF;
    reset = 1'b1;
    idle(2, 2'd3);
    reset = 1'b0;
    idle(10, 2'd3);
    peek(2'd3);
    chk("t3_nocap", rdv[0], 32'd0);
    peek(2'd0);
    chk("t3_data", rdv[0], 32'd1);

    // Bits 0 and 3 toggle on the any-edge instance; partial clear.
    cyc_op(1'b1, 1'b0, 2'd2, 32'hF);
    pin = 4'h6;
    idle(6, 2'd3);
    peek(2'd3);
    chk("t4_any", rdv[1], 32'h9);
    chk("t5_fall", rdv[2], 32'h9);
    cyc_op(1'b1, 1'b0, 2'd3, 32'h1);
    peek(2'd3);
    chk("t4_partclr", rdv[1], 32'h8);
    cyc_op(1'b1, 1'b0, 2'd0, 32'hF);
    cyc_op(1'b1, 1'b0, 2'd1, 32'hF);
    for (int a = 0; a < 4; a++) cyc_op(1'b0, 1'b1, 2'(a), 32'd0);

    // Mid-operation reset with captures and irqs pending.
    pin = 4'hF;
    idle(6, 2'd3);
    chk("t6_irq_pre", {31'd0, irqv[1]}, 32'd1);
    reset = 1'b1;
    #1;
    peek(2'd3);
    chk("t6_irq0", {31'd0, irqv[0]}, 32'd0);
    chk("t6_irq1", {31'd0, irqv[1]}, 32'd0);
    chk("t6_rd1",  rdv[1], 32'd0);
    idle(2, 2'd3);
    reset = 1'b0;
    idle(4, 2'd3);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int r;
      if ($urandom_range(0, 3) == 0) pin = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 1) begin
        reset = 1'b1;
        cyc_op(1'b0, 1'b1, 2'($urandom), 32'd0);
        reset = 1'b0;
      end else if (r < 30) begin
        cyc_op(1'($urandom_range(0, 4) != 0), 1'b0, 2'($urandom), $urandom);
      end else begin
        cyc_op(1'($urandom), 1'b1, 2'($urandom), $urandom);
      end
    end
    idle(4, 2'd3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
